// File: rtl/mcs_multi_bridge_if.sv
// Bus interfaces for the multi-region MCS bridge.
// mcs_io_if carries the MicroBlaze MCS IO bus: the cpu is the master, the bridge the slave.
// mcs_bus_if carries the region-side bus: the bridge is the master, the subsystems the slaves.

interface mcs_io_if;
    logic        io_addr_strobe;
    logic        io_read_strobe;
    logic        io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;
    logic        io_ready;

    modport master (
        output io_addr_strobe, io_read_strobe, io_write_strobe,
               io_byte_enable, io_address, io_write_data,
        input  io_read_data, io_ready
    );

    modport slave (
        input  io_addr_strobe, io_read_strobe, io_write_strobe,
               io_byte_enable, io_address, io_write_data,
        output io_read_data, io_ready
    );
endinterface

interface mcs_bus_if #(
    parameter int N_REGION = 4,
    parameter int ADDR_W   = 20
);
    logic [N_REGION-1:0]    b_cs;
    logic                   b_wr;
    logic                   b_rd;
    logic [ADDR_W-1:0]      b_addr;
    logic [31:0]            b_wr_data;
    logic [3:0]             b_be;
    logic [32*N_REGION-1:0] b_rd_data;
    logic [N_REGION-1:0]    b_ack;

    modport master (
        output b_cs, b_wr, b_rd, b_addr, b_wr_data, b_be,
        input  b_rd_data, b_ack
    );

    modport slave (
        input  b_cs, b_wr, b_rd, b_addr, b_wr_data, b_be,
        output b_rd_data, b_ack
    );
endinterface

// File: rtl/mcs_multi_bridge.sv
// Multi-region bridge between the MicroBlaze MCS IO bus and up to four slave regions.
// Each access is decoded into a one-hot region select. The selected slave finishes the
// access with its ack bit, so slaves may take a variable number of cycles. An access
// that is never acknowledged is aborted by a watchdog. Decode errors and timeouts set a
// sticky error flag and record the failing byte address.

module mcs_multi_bridge #(
    parameter logic [31:0] BRG_BASE = 32'hc000_0000,
    parameter int          N_REGION = 4,
    parameter int          ADDR_W   = 20,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    mcs_io_if.slave     io,
    mcs_bus_if.master   bus,
    input  logic        err_clr,
    output logic        err_flag,
    output logic [31:0] err_addr
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_isWrite;
    logic [31:0]           r_latAddr;

    logic [N_REGION-1:0]   r_cs;
    logic                  r_wr;
    logic                  r_rd;
    logic [ADDR_W-1:0]     r_addr;
    logic [31:0]           r_wrData;
    logic [3:0]            r_be;
    logic [31:0]           r_readData;
    logic                  r_ready;
    logic                  r_errFlag;
    logic [31:0]           r_errAddr;

    logic [1:0]            w_region;
    logic                  w_inWindow;
    logic                  w_badRegion;
    logic                  w_badDir;
    logic [N_REGION-1:0]   w_oneHot;
    logic                  w_ack;
    logic [31:0]           w_selData;

    assign w_region    = io.io_address[23:22];
    assign w_inWindow  = (io.io_address[31:24] == BRG_BASE[31:24]);
    assign w_badRegion = ({30'b0, w_region} >= 32'(N_REGION));
    assign w_badDir    = (io.io_read_strobe == io.io_write_strobe);
    assign w_ack       = |(bus.b_ack & r_cs);

    // Decode the incoming region index into a one-hot select for the bus.
    always_comb begin
        w_oneHot = '0;
        for (int r = 0; r < N_REGION; r++) begin
            if (w_region == 2'(r)) begin
                w_oneHot[r] = 1'b1;
            end
        end
    end

    // Pick the read-data slice of the region currently selected; other regions never contribute.
    always_comb begin
        w_selData = '0;
        for (int r = 0; r < N_REGION; r++) begin
            if (r_cs[r]) begin
                w_selData = w_selData | bus.b_rd_data[32*r +: 32];
            end
        end
    end

    // Access sequencer: accept, issue, wait for ack or watchdog, respond; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_isWrite  <= 1'b0;
            r_latAddr  <= '0;
            r_cs       <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_addr     <= '0;
            r_wrData   <= '0;
            r_be       <= '0;
            r_readData <= '0;
            r_ready    <= 1'b0;
            r_errFlag  <= 1'b0;
            r_errAddr  <= '0;
        end else begin
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_ready    <= 1'b0;
            r_readData <= '0;
            if (err_clr) begin
                r_errFlag <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (io.io_addr_strobe && w_inWindow) begin
                        r_latAddr <= io.io_address;
                        r_isWrite <= io.io_write_strobe;
                        if (w_badRegion || w_badDir) begin
                            r_state   <= RESP;
                            r_ready   <= 1'b1;
                            r_errFlag <= 1'b1;
                            r_errAddr <= io.io_address;
                        end else begin
                            r_state  <= ISSUE;
                            r_cs     <= w_oneHot;
                            r_addr   <= io.io_address[ADDR_W+1:2];
                            r_wrData <= io.io_write_data;
                            r_be     <= io.io_byte_enable;
                            r_wr     <= io.io_write_strobe;
                            r_rd     <= io.io_read_strobe;
                        end
                    end
                end

                ISSUE, WAIT: begin
                    if (w_ack) begin
                        r_state    <= RESP;
                        r_ready    <= 1'b1;
                        r_readData <= r_isWrite ? 32'h0 : w_selData;
                        r_cs       <= '0;
                        r_addr     <= '0;
                        r_wrData   <= '0;
                        r_be       <= '0;
                    end else if (r_state == ISSUE) begin
                        r_state <= WAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= RESP;
                        r_ready   <= 1'b1;
                        r_errFlag <= 1'b1;
                        r_errAddr <= r_latAddr;
                        r_cs      <= '0;
                        r_addr    <= '0;
                        r_wrData  <= '0;
                        r_be      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RESP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io.io_read_data = r_readData;
    assign io.io_ready     = r_ready;
    assign bus.b_cs        = r_cs;
    assign bus.b_wr        = r_wr;
    assign bus.b_rd        = r_rd;
    assign bus.b_addr      = r_addr;
    assign bus.b_wr_data   = r_wrData;
    assign bus.b_be        = r_be;
    assign err_flag        = r_errFlag;
    assign err_addr        = r_errAddr;

endmodule
